// File: rtl/baw_pkg.sv
// Shared constants, types and the switch encoder for the black-and-white
// card game input stage.
package baw_pkg;

  localparam int unsigned BTN_CENTER = 0;
  localparam int unsigned BTN_TOP    = 1;
  localparam int unsigned BTN_BOTTOM = 2;
  localparam int unsigned BTN_LEFT   = 3;
  localparam int unsigned BTN_RIGHT  = 4;

  localparam int unsigned BTN_COUNT = 5;
  localparam int unsigned SW_COUNT  = 9;

  localparam logic [3:0] SW_INDEX_NONE = 4'hF;

  typedef logic [BTN_COUNT-1:0] btn_vec_t;
  typedef logic [SW_COUNT-1:0]  sw_vec_t;

  typedef struct packed {
    logic       onehot;
    logic [3:0] index;
  } sw_code_t;

  // Zero or multiple set bits collapse to "no card selected".
  function automatic sw_code_t sw_encode(sw_vec_t v);
    sw_code_t    c;
    int unsigned ones;
    c.onehot = 1'b0;
    c.index  = SW_INDEX_NONE;
    ones     = 0;
    for (int unsigned i = 0; i < SW_COUNT; i++) begin
      if (v[i]) ones++;
    end
    if (ones == 1) begin
      for (int unsigned i = 0; i < SW_COUNT; i++) begin
        if (v[i]) begin
          c.onehot = 1'b1;
          c.index  = 4'(i);
        end
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/baw_input_conditioner_if.sv
// Raw inputs and conditioned outputs of the input stage; the conditioner
// uses the slave view, its driver/consumer the master view.
interface baw_input_conditioner_if;
  import baw_pkg::*;

  btn_vec_t   btn_raw;
  sw_vec_t    sw_raw;
  btn_vec_t   btn_pulse;
  btn_vec_t   btn_level;
  sw_vec_t    sw_sync;
  logic       sw_onehot;
  logic [3:0] sw_index;

  modport master (
    output btn_raw, sw_raw,
    input  btn_pulse, btn_level, sw_sync, sw_onehot, sw_index
  );

  modport slave (
    input  btn_raw, sw_raw,
    output btn_pulse, btn_level, sw_sync, sw_onehot, sw_index
  );

endinterface

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, stability counter, debounced level,
// arm bit and press (rise) candidate.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic             arm_q, arm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    // Arming needs a seen-released button, so a press held through reset never pulses.
    arm_d   = arm_q | (~level_q & ~s2_q);
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise = arm_q & ~level_q & level_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      level_q <= 1'b0;
      arm_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/baw_input_conditioner.sv
// Input stage top: per-button debounce, fixed-priority press arbiter and
// synchronised one-hot card-select encoder.
module baw_input_conditioner
  import baw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                    clk,
  input  logic                    reset_n,
  baw_input_conditioner_if.slave  io
);

  btn_vec_t level;
  btn_vec_t cand;
  btn_vec_t pulse_q, pulse_d;
  sw_vec_t  sw_s1_q, sw_s2_q;
  sw_code_t code_q, code_d;

  for (genvar b = 0; b < BTN_COUNT; b++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (io.btn_raw[b]),
      .level   (level[b]),
      .rise    (cand[b])
    );
  end

  // Losing candidates are dropped outright, never queued for a later cycle.
  always_comb begin
    pulse_d = '0;
    if      (cand[BTN_CENTER]) pulse_d[BTN_CENTER] = 1'b1;
    else if (cand[BTN_TOP])    pulse_d[BTN_TOP]    = 1'b1;
    else if (cand[BTN_BOTTOM]) pulse_d[BTN_BOTTOM] = 1'b1;
    else if (cand[BTN_LEFT])   pulse_d[BTN_LEFT]   = 1'b1;
    else if (cand[BTN_RIGHT])  pulse_d[BTN_RIGHT]  = 1'b1;
  end

  always_comb begin
    code_d = sw_encode(sw_s2_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_q <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      code_q  <= '{onehot: 1'b0, index: SW_INDEX_NONE};
    end else begin
      pulse_q <= pulse_d;
      sw_s1_q <= io.sw_raw;
      sw_s2_q <= sw_s1_q;
      code_q  <= code_d;
    end
  end

  assign io.btn_pulse = pulse_q;
  assign io.btn_level = level;
  assign io.sw_sync   = sw_s2_q;
  assign io.sw_onehot = code_q.onehot;
  assign io.sw_index  = code_q.index;

endmodule

// File: tb/tb_baw_input_conditioner.sv
// Directed and randomised bench for baw_input_conditioner against a
// sample-history reference model (DEBOUNCE_CYCLES = 4).
module tb_baw_input_conditioner;
  import baw_pkg::*;

  localparam int unsigned DEB = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  baw_input_conditioner_if io ();

  baw_input_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io)
  );

  // Reference model: a button level flips once the last DEB synchronised
  // samples all disagree with it.
  bit         m_s1 [BTN_COUNT];
  bit         m_s2 [BTN_COUNT];
  bit         m_lvl[BTN_COUNT];
  bit         m_arm[BTN_COUNT];
  bit         m_hist[BTN_COUNT][$];
  logic [4:0] m_pulse;
  logic [8:0] ms1, ms2;
  logic       m_oh;
  logic [3:0] m_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < BTN_COUNT; b++) begin
      m_s1[b] = 1'b1; m_s2[b] = 1'b1; m_lvl[b] = 1'b0; m_arm[b] = 1'b0;
      m_hist[b].delete();
    end
    m_pulse = '0; ms1 = '0; ms2 = '0; m_oh = 1'b0; m_idx = 4'hF;
  endtask

  task automatic model_step(input logic [4:0] btn, input logic [8:0] sw);
    logic [4:0] rise;
    int         ones;
    rise = '0;
    for (int b = 0; b < BTN_COUNT; b++) begin
      bit s2, all_differ, arm_old;
      s2      = m_s2[b];
      arm_old = m_arm[b];
      m_s2[b] = m_s1[b];
      m_s1[b] = btn[b];
      m_hist[b].push_back(s2);
      if (m_hist[b].size() > DEB) void'(m_hist[b].pop_front());
      if (!m_lvl[b] && !s2) m_arm[b] = 1'b1;
      all_differ = (m_hist[b].size() == DEB);
      for (int k = 0; k < m_hist[b].size(); k++)
        if (m_hist[b][k] == m_lvl[b]) all_differ = 1'b0;
      if (all_differ) begin
        m_lvl[b] = ~m_lvl[b];
        if (m_lvl[b] && arm_old) rise[b] = 1'b1;
      end
    end
    m_pulse = '0;
    for (int b = BTN_COUNT - 1; b >= 0; b--)
      if (rise[b]) m_pulse = 5'(1 << b);
    ones = $countones(ms2);
    m_oh = (ones == 1);
    m_idx = 4'hF;
    if (ones == 1)
      for (int i = 0; i < SW_COUNT; i++) if (ms2[i]) m_idx = 4'(i);
    ms2 = ms1;
    ms1 = sw;
  endtask

  function automatic logic [4:0] m_level();
    logic [4:0] v;
    for (int b = 0; b < BTN_COUNT; b++) v[b] = m_lvl[b];
    return v;
  endfunction

  task automatic compare_all();
    check("btn_pulse", io.btn_pulse, m_pulse);
    check("btn_level", io.btn_level, m_level());
    check("sw_sync",   io.sw_sync,   ms2);
    check("sw_onehot", io.sw_onehot, m_oh);
    check("sw_index",  io.sw_index,  m_idx);
  endtask

  task automatic cycle(input logic [4:0] btn, input logic [8:0] sw);
    io.btn_raw = btn;
    io.sw_raw  = sw;
    @(posedge clk);
    model_step(btn, sw);
    @(negedge clk);
    compare_all();
  endtask

  // Called at a negedge; asserts reset asynchronously, checks, releases.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    check("rst_pulse", io.btn_pulse, 5'b0);
    check("rst_index", io.sw_index, 4'hF);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run(input logic [4:0] btn, input int n, input int bit_i, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      cycle(btn, 9'b0);
      if (io.btn_pulse[bit_i]) pulses++;
    end
  endtask

  initial begin
    int n, p, found;
    logic [4:0] rb;
    logic [8:0] rs;
    reset_n    = 1'b0;
    io.btn_raw = '0;
    io.sw_raw  = '0;
    @(negedge clk);
    do_reset();
    run(5'b0, 6, 0, p);

    // Clean press: pulse lands after the sixth edge once raw is stable.
    n = 0; found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      cycle(5'b00001, 9'b0);
      n++;
      if (io.btn_pulse[0]) found = 1;
    end
    check("clean_latency", n, 6);
    run(5'b00001, 1, 0, p);
    check("clean_one_cycle", p, 0);
    run(5'b00001, 5, 0, p);
    check("clean_level_held", io.btn_level[0], 1'b1);
    run(5'b0, 10, 0, p);
    check("release_no_pulse", p, 0);

    // Bounce on top button.
    p = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(((i / 2) % 2 == 0) ? 5'b00010 : 5'b00000, 9'b0);
      if (io.btn_pulse[1]) p++;
    end
    check("bounce_quiet", p, 0);
    run(5'b00010, 5, 1, p);
    check("bounce_early", p, 0);
    run(5'b00010, 1, 1, p);
    check("bounce_sixth_edge", p, 1);
    run(5'b00010, 6, 1, p);
    check("bounce_single", p, 0);
    run(5'b0, 10, 1, p);

    // Simultaneous top + left: only top pulses.
    run(5'b01010, 10, 3, p);
    check("simul_left_dropped", p, 0);
    check("simul_level", io.btn_level, 5'b01010);
    run(5'b0, 10, 0, p);

    // Held through reset.
    io.btn_raw = 5'b00001;
    do_reset();
    run(5'b00001, 10, 0, p);
    check("held_reset_no_pulse", p, 0);
    run(5'b0, 10, 0, p);
    run(5'b00001, 8, 0, p);
    check("held_reset_repress", p, 1);
    run(5'b0, 10, 0, p);

    // Switch encoding: three edges from raw to index.
    cycle(5'b0, 9'b000010000);
    cycle(5'b0, 9'b000010000);
    cycle(5'b0, 9'b000010000);
    check("sw_one_idx", io.sw_index, 4'd4);
    check("sw_one_oh", io.sw_onehot, 1'b1);
    for (int i = 0; i < 3; i++) cycle(5'b0, 9'b000010001);
    check("sw_two_idx", io.sw_index, 4'hF);
    for (int i = 0; i < 3; i++) cycle(5'b0, 9'b0);
    check("sw_zero_oh", io.sw_onehot, 1'b0);

    // Reset mid-debounce on right button (count reaches 2).
    run(5'b10000, 4, 4, p);
    io.btn_raw = 5'b10000;
    do_reset();
    check("middeb_level", io.btn_level, 5'b0);
    run(5'b10000, 10, 4, p);
    check("middeb_no_pulse", p, 0);
    run(5'b0, 10, 4, p);
    run(5'b10000, 8, 4, p);
    check("middeb_repress", p, 1);

    // Random phase: slowly varying buttons, mostly one-hot switches.
    rb = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < BTN_COUNT; b++)
        if ($urandom_range(7) == 0) rb[b] = ~rb[b];
      if ($urandom_range(3) == 0) rs = 9'($urandom_range(511));
      else rs = 9'(1 << $urandom_range(8));
      if ($urandom_range(150) == 0) begin
        io.btn_raw = rb;
        do_reset();
      end else begin
        cycle(rb, rs);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
